// File: rtl/bt_cmd_ctrl.sv
// Bluetooth UART command framer: HEADER, op, arg_hi, arg_lo, chk -> one command.
// Ports: clk, rst (sync, high); rx_data/rx_valid in; cmd_ready in;
//        cmd_valid/cmd_op/cmd_arg out; err_pulse/err_code out; busy, state_out out.
module bt_cmd_ctrl #(
    parameter logic [7:0] HEADER      = 8'hA5,
    parameter int         TIMEOUT_CYC = 2_000_000,
    parameter int         CNT_W       = 21
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        cmd_ready,
    output logic        cmd_valid,
    output logic [7:0]  cmd_op,
    output logic [15:0] cmd_arg,
    output logic        err_pulse,
    output logic [1:0]  err_code,
    output logic        busy,
    output logic [5:0]  state_out
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_OP    = 3'd1,
        S_ARG_H = 3'd2,
        S_ARG_L = 3'd3,
        S_CHK   = 3'd4,
        S_HOLD  = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC - 1);
    // Timeout fires on the edge where the counter would reach CNT_MAX.
    localparam logic [CNT_W-1:0] CNT_HIT = CNT_W'(TIMEOUT_CYC - 2);

    localparam logic [1:0] E_TMO = 2'b01;
    localparam logic [1:0] E_CHK = 2'b10;
    localparam logic [1:0] E_OVF = 2'b11;

    state_t           state;
    state_t           state_n;
    logic [CNT_W-1:0] cnt;
    logic [7:0]       op_q;
    logic [7:0]       arg_hi_q;
    logic [7:0]       arg_lo_q;
    logic             timing;
    logic             tmo;
    logic             err_set;
    logic [1:0]       err_val;
    logic             load_cmd;

    function automatic logic [5:0] onehot(input state_t s);
        return 6'b000001 << s;
    endfunction

    assign timing = (state == S_OP) || (state == S_ARG_H) ||
                    (state == S_ARG_L) || (state == S_CHK);
    // A byte on the expiry cycle wins over the timeout.
    assign tmo = timing && !rx_valid && (cnt == CNT_HIT);

    always_comb begin
        state_n  = state;
        err_set  = 1'b0;
        err_val  = 2'b00;
        load_cmd = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (rx_valid && rx_data == HEADER)
                    state_n = S_OP;
            end
            S_OP: begin
                if (rx_valid)
                    state_n = S_ARG_H;
                else if (tmo) begin
                    state_n = S_IDLE;
                    err_set = 1'b1;
                    err_val = E_TMO;
                end
            end
            S_ARG_H: begin
                if (rx_valid)
                    state_n = S_ARG_L;
                else if (tmo) begin
                    state_n = S_IDLE;
                    err_set = 1'b1;
                    err_val = E_TMO;
                end
            end
            S_ARG_L: begin
                if (rx_valid)
                    state_n = S_CHK;
                else if (tmo) begin
                    state_n = S_IDLE;
                    err_set = 1'b1;
                    err_val = E_TMO;
                end
            end
            S_CHK: begin
                if (rx_valid) begin
                    if (rx_data == (op_q ^ arg_hi_q ^ arg_lo_q)) begin
                        state_n  = S_HOLD;
                        load_cmd = 1'b1;
                    end else begin
                        state_n = S_IDLE;
                        err_set = 1'b1;
                        err_val = E_CHK;
                    end
                end else if (tmo) begin
                    state_n = S_IDLE;
                    err_set = 1'b1;
                    err_val = E_TMO;
                end
            end
            S_HOLD: begin
                // No pipelining: any byte here is lost, even a header.
                if (cmd_ready)
                    state_n = S_IDLE;
                if (rx_valid) begin
                    err_set = 1'b1;
                    err_val = E_OVF;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            op_q      <= '0;
            arg_hi_q  <= '0;
            arg_lo_q  <= '0;
            cmd_valid <= 1'b0;
            cmd_op    <= '0;
            cmd_arg   <= '0;
            err_pulse <= 1'b0;
            err_code  <= 2'b00;
            busy      <= 1'b0;
            state_out <= 6'b000001;
        end else begin
            state     <= state_n;
            busy      <= (state_n != S_IDLE);
            state_out <= onehot(state_n);
            err_pulse <= err_set;
            if (err_set)
                err_code <= err_val;

            if (!timing || rx_valid || state_n != state)
                cnt <= '0;
            else if (cnt != CNT_MAX)
                cnt <= cnt + CNT_W'(1);

            if (rx_valid) begin
                if (state == S_OP)
                    op_q <= rx_data;
                if (state == S_ARG_H)
                    arg_hi_q <= rx_data;
                if (state == S_ARG_L)
                    arg_lo_q <= rx_data;
            end

            if (load_cmd) begin
                cmd_valid <= 1'b1;
                cmd_op    <= op_q;
                cmd_arg   <= {arg_hi_q, arg_lo_q};
            end else if (state == S_HOLD && cmd_ready) begin
                cmd_valid <= 1'b0;
            end
        end
    end

endmodule
